game_state_sequencer: RTL and testbench
=======================================

GAME_STATE_SEQUENCER -- requirements
Module: game_state_sequencer

Interface
REQ-001 SHALL have parameter AUTH_MSG_TICKS, default 2000, number of tick pulses the auth result state (0x01/0x02) is held; legal range 1..65535.
REQ-002 SHALL have parameter END_SEQ_TICKS, default 3000, number of tick pulses the begin states (0x20/0x30) are held; legal range 1..65535.
REQ-003 SHALL have parameter MAX_STRIKES, default 3, number of strikes that ends the game; legal range 1..3.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 tick  input  1  one-cycle timebase enable pulse; dwell counters advance only on cycles with tick=1.
REQ-007 auth_valid  input  1  one-cycle pulse: authentication attempt complete.
REQ-008 auth_ok  input  1  qualifies auth_valid: 1 = success, 0 = failure.
REQ-009 defuse_done  input  1  level/pulse: bomb defused.
REQ-010 timer_expired  input  1  level/pulse: game countdown reached zero.
REQ-011 strike  input  1  one-cycle pulse: wrong wire/input.
REQ-012 restart  input  1  one-cycle pulse: operator requests a new game.
REQ-013 state  output  8  registered game state code driven to the LED driver.
REQ-014 state_changed  output  1  one-cycle pulse, high in the first cycle a new state value is presented.
REQ-015 strikes  output  2  registered strike count for the current game.

Function
REQ-016 state SHALL take only the codes AUTH=0x00, AUTH_OK=0x01, AUTH_FAIL=0x02, GAME=0x10, WIN_BEGIN=0x20, WIN_END=0x21, LOSE_BEGIN=0x30, LOSE_END=0x31.
REQ-017 AUTH: auth_valid=1 with auth_ok=1 -> AUTH_OK; auth_valid=1 with auth_ok=0 -> AUTH_FAIL; all other inputs ignored.
REQ-018 AUTH_OK SHALL hold for exactly AUTH_MSG_TICKS tick pulses, then -> GAME.
REQ-019 AUTH_FAIL SHALL hold for exactly AUTH_MSG_TICKS tick pulses, then -> AUTH.
REQ-020 GAME: timer_expired=1 -> LOSE_BEGIN; strike=1 with strikes==MAX_STRIKES-1 -> LOSE_BEGIN; else defuse_done=1 -> WIN_BEGIN.
REQ-021 In GAME, loss conditions SHALL take priority over defuse_done when asserted in the same cycle.
REQ-022 strikes SHALL increment by 1 per strike pulse only while state==GAME, saturate at MAX_STRIKES, and clear to 0 on every entry into GAME.
REQ-023 WIN_BEGIN SHALL hold for exactly END_SEQ_TICKS tick pulses, then -> WIN_END; LOSE_BEGIN likewise -> LOSE_END.
REQ-024 WIN_END and LOSE_END SHALL hold indefinitely until restart=1, then -> AUTH.
REQ-025 restart SHALL be ignored in every state other than WIN_END and LOSE_END.
REQ-026 Dwell counter (16 bit) SHALL clear to 0 on every state transition; in a timed state it increments on tick=1 and the transition occurs on the cycle where counter==N-1 and tick=1 (N = governing parameter).
REQ-027 Transition latency SHALL be one cycle: the triggering input in cycle t yields new state and state_changed=1 in cycle t+1.
REQ-028 state_changed SHALL be 0 in every cycle where state equals its previous-cycle value.
REQ-029 A tick pulse on the same cycle as a transition SHALL NOT be counted toward the new state's dwell.

Reset
REQ-030 While reset=0 at a rising edge: state=0x00, strikes=0, state_changed=0, dwell counter=0.
REQ-031 Reset asserted mid-sequence (any state, any counter value) SHALL abort to AUTH with no residual dwell or strike count.
REQ-032 First cycle after reset release SHALL show state=0x00, state_changed=0.

Verification (AUTH_MSG_TICKS=4, END_SEQ_TICKS=6, MAX_STRIKES=3, tick every 2nd cycle)
REQ-033 auth_valid=1, auth_ok=1 -> state 0x01 next cycle with state_changed=1, 0x10 after 4th tick, strikes=0.
REQ-034 auth_valid=1, auth_ok=0 -> 0x02, back to 0x00 after 4 ticks; auth_valid then ignored until 0x00 presented.
REQ-035 In GAME, 2 strikes -> strikes=2, state 0x10; 3rd strike -> 0x30, strikes=3; after 6 ticks 0x31; restart -> 0x00.
REQ-036 In GAME, defuse_done and timer_expired same cycle -> 0x30 (not 0x20); separately defuse_done alone -> 0x20, 0x21 after 6 ticks.
REQ-037 restart pulsed in 0x10 and 0x20 -> no state change; reset=0 during 0x20 at dwell count 3 -> 0x00, strikes=0, fresh 6-tick dwell on next win.

Source files
------------

// File: rtl/game_state_sequencer.sv
// Game-flow sequencer: auth -> game -> win/lose, with tick-timed message states.
// Drives an 8-bit state code to the LED driver plus a change strobe and strike count.
module game_state_sequencer #(
    parameter int AUTH_MSG_TICKS = 2000,
    parameter int END_SEQ_TICKS  = 3000,
    parameter int MAX_STRIKES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       auth_valid,
    input  logic       auth_ok,
    input  logic       defuse_done,
    input  logic       timer_expired,
    input  logic       strike,
    input  logic       restart,
    output logic [7:0] state,
    output logic       state_changed,
    output logic [1:0] strikes
);

    localparam logic [7:0] S_AUTH       = 8'h00;
    localparam logic [7:0] S_AUTH_OK    = 8'h01;
    localparam logic [7:0] S_AUTH_FAIL  = 8'h02;
    localparam logic [7:0] S_GAME       = 8'h10;
    localparam logic [7:0] S_WIN_BEGIN  = 8'h20;
    localparam logic [7:0] S_WIN_END    = 8'h21;
    localparam logic [7:0] S_LOSE_BEGIN = 8'h30;
    localparam logic [7:0] S_LOSE_END   = 8'h31;

    localparam logic [15:0] AUTH_LAST = 16'(AUTH_MSG_TICKS - 1);
    localparam logic [15:0] END_LAST  = 16'(END_SEQ_TICKS - 1);
    localparam logic [1:0]  LOSE_AT   = 2'(MAX_STRIKES - 1);
    localparam logic [1:0]  STR_MAX   = 2'(MAX_STRIKES);

    logic [7:0]  next;
    logic [15:0] dwell;
    logic        timed;

    always_comb begin
        next  = state;
        timed = 1'b0;
        case (state)
            S_AUTH: if (auth_valid) next = auth_ok ? S_AUTH_OK : S_AUTH_FAIL;
            S_AUTH_OK: begin
                timed = 1'b1;
                if (tick && dwell == AUTH_LAST) next = S_GAME;
            end
            S_AUTH_FAIL: begin
                timed = 1'b1;
                if (tick && dwell == AUTH_LAST) next = S_AUTH;
            end
            // Loss outranks a same-cycle defuse.
            S_GAME: begin
                if (timer_expired || (strike && strikes == LOSE_AT)) next = S_LOSE_BEGIN;
                else if (defuse_done)                                next = S_WIN_BEGIN;
            end
            S_WIN_BEGIN: begin
                timed = 1'b1;
                if (tick && dwell == END_LAST) next = S_WIN_END;
            end
            S_LOSE_BEGIN: begin
                timed = 1'b1;
                if (tick && dwell == END_LAST) next = S_LOSE_END;
            end
            S_WIN_END, S_LOSE_END: if (restart) next = S_AUTH;
            default: next = S_AUTH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_AUTH;
            state_changed <= 1'b0;
            strikes       <= 2'd0;
            dwell         <= 16'd0;
        end else begin
            state         <= next;
            state_changed <= (next != state);
            // A tick coinciding with a transition is dropped, not carried over.
            if (next != state)      dwell <= 16'd0;
            else if (timed && tick) dwell <= dwell + 16'd1;
            if (next == S_GAME && state != S_GAME)
                strikes <= 2'd0;
            else if (state == S_GAME && strike && strikes != STR_MAX)
                strikes <= strikes + 2'd1;
        end
    end

endmodule

// File: tb/tb_game_state_sequencer.sv
// Bench for game_state_sequencer: remaining-ticks reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_game_state_sequencer;

    localparam int AUTH_T = 4;
    localparam int END_T  = 6;
    localparam int MAXS   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       auth_valid = 1'b0;
    logic       auth_ok = 1'b0;
    logic       defuse_done = 1'b0;
    logic       timer_expired = 1'b0;
    logic       strike = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] state;
    logic       state_changed;
    logic [1:0] strikes;

    int tests = 0;
    int fails = 0;
    bit phase = 1'b0;
    bit ticked = 1'b0;
    bit model_on = 1'b0;

    game_state_sequencer #(
        .AUTH_MSG_TICKS(AUTH_T),
        .END_SEQ_TICKS (END_T),
        .MAX_STRIKES   (MAXS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .auth_valid   (auth_valid),
        .auth_ok      (auth_ok),
        .defuse_done  (defuse_done),
        .timer_expired(timer_expired),
        .strike       (strike),
        .restart      (restart),
        .state        (state),
        .state_changed(state_changed),
        .strikes      (strikes)
    );

    always #5 clk = ~clk;

    // Reference model: timed states count remaining ticks down to the exit.
    logic [7:0] m_state = 8'h00;
    logic [7:0] m_nx;
    int         m_str = 0;
    int         m_ns;
    int         m_rem = 0;
    bit         m_chg = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_state = 8'h00; m_str = 0; m_rem = 0; m_chg = 1'b0;
        end else begin
            m_nx = m_state;
            m_ns = m_str;
            case (m_state)
                8'h00: if (auth_valid) m_nx = auth_ok ? 8'h01 : 8'h02;
                8'h01, 8'h02, 8'h20, 8'h30:
                    if (tick) begin
                        if (m_rem == 1)
                            m_nx = (m_state == 8'h01) ? 8'h10 :
                                   (m_state == 8'h02) ? 8'h00 : m_state + 8'h01;
                        else
                            m_rem = m_rem - 1;
                    end
                8'h10: begin
                    if (strike) m_ns = (m_str + 1 > MAXS) ? MAXS : m_str + 1;
                    if (timer_expired || (strike && m_str + 1 == MAXS)) m_nx = 8'h30;
                    else if (defuse_done) m_nx = 8'h20;
                end
                8'h21, 8'h31: if (restart) m_nx = 8'h00;
                default: m_nx = 8'h00;
            endcase
            m_chg = (m_nx != m_state);
            if (m_chg) begin
                m_rem = (m_nx == 8'h01 || m_nx == 8'h02) ? AUTH_T :
                        (m_nx == 8'h20 || m_nx == 8'h30) ? END_T : 0;
                if (m_nx == 8'h10) m_ns = 0;
            end
            m_state = m_nx;
            m_str   = m_ns;
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_on) begin
            tests += 3;
            if (state !== m_state) begin
                fails++; $display("FAIL model_state t=%0t got %h exp %h", $time, state, m_state);
            end
            if (strikes !== 2'(m_str)) begin
                fails++; $display("FAIL model_strikes t=%0t got %0d exp %0d", $time, strikes, m_str);
            end
            if (state_changed !== m_chg) begin
                fails++; $display("FAIL model_changed t=%0t got %b exp %b", $time, state_changed, m_chg);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // One clock: tick on alternate cycles; outputs are settled on return.
    task automatic step();
        tick  = phase;
        phase = ~phase;
        @(posedge clk);
        ticked = tick;
        #1;
    endtask

    task automatic pulse_auth(input bit ok);
        auth_valid = 1'b1; auth_ok = ok; step(); auth_valid = 1'b0; auth_ok = 1'b0;
    endtask

    task automatic wait_state(input logic [7:0] exp, input int maxc, output int nt);
        int i;
        nt = 0;
        for (i = 0; i < maxc && state !== exp; i++) begin
            step();
            if (ticked) nt++;
        end
        if (state !== exp) begin
            tests++; fails++;
            $display("FAIL timeout_wait_%h got %h", exp, state);
        end
    endtask

    task automatic enter_game();
        int nt;
        pulse_auth(1'b1);
        chk("auth_ok_state", state, 8'h01);
        chk("auth_ok_changed", state_changed, 1);
        wait_state(8'h10, 40, nt);
        chk("auth_ok_ticks", nt, AUTH_T);
        chk("game_strikes_zero", strikes, 0);
    endtask

    initial begin
        int nt;
        model_on = 1'b1;
        repeat (3) step();
        chk("reset_state", state, 8'h00);
        chk("reset_strikes", strikes, 0);
        chk("reset_changed", state_changed, 0);
        reset = 1'b1;
        step();
        chk("post_reset_state", state, 8'h00);
        chk("post_reset_changed", state_changed, 0);

        // Failed auth, with an auth attempt ignored during the fail message.
        pulse_auth(1'b0);
        chk("auth_fail_state", state, 8'h02);
        chk("auth_fail_changed", state_changed, 1);
        step();
        chk("auth_fail_hold_changed", state_changed, 0);
        pulse_auth(1'b1);
        chk("auth_fail_ignores_valid", state, 8'h02);
        wait_state(8'h00, 40, nt);
        chk("back_to_auth", state, 8'h00);

        // Strike-out loss.
        enter_game();
        strike = 1'b1; step(); strike = 1'b0; step();
        strike = 1'b1; step(); strike = 1'b0;
        chk("two_strikes", strikes, 2);
        chk("two_strikes_state", state, 8'h10);
        strike = 1'b1; step(); strike = 1'b0;
        chk("third_strike_state", state, 8'h30);
        chk("third_strike_count", strikes, 3);
        wait_state(8'h31, 40, nt);
        chk("lose_ticks", nt, END_T);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_from_lose", state, 8'h00);

        // restart ignored in GAME; loss beats defuse in the same cycle.
        enter_game();
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_in_game", state, 8'h10);
        defuse_done = 1'b1; timer_expired = 1'b1; step();
        defuse_done = 1'b0; timer_expired = 1'b0;
        chk("loss_priority", state, 8'h30);
        wait_state(8'h31, 40, nt);
        restart = 1'b1; step(); restart = 1'b0;

        // Clean win; restart ignored in WIN_BEGIN.
        enter_game();
        defuse_done = 1'b1; step(); defuse_done = 1'b0;
        chk("win_begin", state, 8'h20);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_in_win_begin", state, 8'h20);
        wait_state(8'h21, 40, nt);
        chk("win_end", state, 8'h21);
        step();
        chk("win_end_holds", state, 8'h21);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_from_win", state, 8'h00);

        // Reset mid-dwell (3 ticks into WIN_BEGIN), then a fresh win.
        enter_game();
        strike = 1'b1; step(); strike = 1'b0;
        defuse_done = 1'b1; step(); defuse_done = 1'b0;
        chk("win_begin_2", state, 8'h20);
        nt = 0;
        for (int i = 0; i < 20 && nt < 3; i++) begin
            step();
            if (ticked) nt++;
        end
        chk("dwell_three", nt, 3);
        reset = 1'b0; step(); reset = 1'b1;
        chk("midreset_state", state, 8'h00);
        chk("midreset_strikes", strikes, 0);
        chk("midreset_changed", state_changed, 0);
        step();
        enter_game();
        defuse_done = 1'b1; step(); defuse_done = 1'b0;
        wait_state(8'h21, 40, nt);
        chk("fresh_win_ticks", nt, END_T);

        step();
        model_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
